// File: rtl/perceptron_pkg.sv
// Shared constants and parser state encoding for the UART-driven perceptron MAC.
package perceptron_pkg;

   localparam int DATA_W = 32;

   localparam logic [7:0] OP_LOAD_A  = 8'd0;
   localparam logic [7:0] OP_LOAD_B  = 8'd1;
   localparam logic [7:0] OP_OUT_RES = 8'd2;
   localparam logic [7:0] OP_CLR     = 8'd3;
   localparam logic [7:0] OP_MUL     = 8'd5;
   localparam logic [7:0] OP_MAC     = 8'd6;
   localparam logic [7:0] OP_OUT_ACT = 8'd7;

   typedef enum logic [2:0] {
      ST_IDLE, ST_OP, ST_PAY0, ST_PAY1, ST_PAY2, ST_PAY3, ST_EXEC, ST_SEND
   } parse_state_e;

   function automatic logic has_payload(input logic [7:0] op);
      return (op == OP_LOAD_A) || (op == OP_LOAD_B);
   endfunction

   function automatic logic is_exec_op(input logic [7:0] op);
      return op inside {OP_OUT_RES, OP_CLR, OP_MUL, OP_MAC, OP_OUT_ACT};
   endfunction

endpackage

// File: rtl/perceptron_uart.sv
// 8N1 UART: synchronised receiver with centre sampling and a one-byte transmitter.
module perceptron_uart #(
   parameter int CLK_PER_BIT = 430
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       host_tx,
   output logic       uart_tx,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_busy
);

   localparam int CNT_W = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_PER_BIT / 2 - 1);

   // rx_s[1:0] is the 2-flop synchroniser; rx_s[2] is the previous synced value for edge detect
   logic [2:0]       rx_s;
   logic             rx_busy;
   logic [CNT_W-1:0] rx_cnt;
   logic [3:0]       rx_idx;
   logic [7:0]       rx_sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s     <= 3'b111;
         rx_busy  <= 1'b0;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_sh    <= '0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
      end else begin
         rx_s     <= {rx_s[1:0], host_tx};
         rx_valid <= 1'b0;
         if (!rx_busy) begin
            if (rx_s[2] && !rx_s[1]) begin
               rx_busy <= 1'b1;
               rx_cnt  <= '0;
               rx_idx  <= '0;
            end
         end else if (rx_cnt != ((rx_idx == 4'd0) ? HALF_END : BIT_END)) begin
            rx_cnt <= rx_cnt + 1'b1;
         end else begin
            rx_cnt <= '0;
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx == 4'd0) begin
               // start bit gone high again at its centre: treat as a glitch
               if (rx_s[1]) rx_busy <= 1'b0;
            end else if (rx_idx == 4'd9) begin
               rx_busy <= 1'b0;
               if (rx_s[1]) begin
                  rx_valid <= 1'b1;
                  rx_byte  <= rx_sh;
               end
            end else begin
               rx_sh <= {rx_s[1], rx_sh[7:1]};
            end
         end
      end
   end

   logic [CNT_W-1:0] tx_cnt;
   logic [3:0]       tx_left;
   logic [8:0]       tx_sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uart_tx <= 1'b1;
         tx_busy <= 1'b0;
         tx_cnt  <= '0;
         tx_left <= '0;
         tx_sh   <= '1;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy <= 1'b1;
            uart_tx <= 1'b0;
            tx_sh   <= {1'b1, tx_byte};
            tx_left <= 4'd9;
            tx_cnt  <= '0;
         end
      end else if (tx_cnt != BIT_END) begin
         tx_cnt <= tx_cnt + 1'b1;
      end else begin
         tx_cnt <= '0;
         if (tx_left == 4'd0) begin
            tx_busy <= 1'b0;
         end else begin
            uart_tx <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[8:1]};
            tx_left <= tx_left - 4'd1;
         end
      end
   end

endmodule

// File: rtl/perceptron_core.sv
// Single-neuron MAC engine: UART command parser, A/B/R datapath and response sequencer.
module perceptron_core
   import perceptron_pkg::*;
#(
   parameter int         CLK_PER_BIT = 430,
   parameter logic [7:0] DEV_ADDR    = 8'h00
) (
   input  logic clk,
   input  logic rst,
   input  logic host_tx,
   output logic uart_tx
);

   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       tx_start;
   logic [7:0] tx_byte;
   logic       tx_busy;

   perceptron_uart #(.CLK_PER_BIT(CLK_PER_BIT)) u_uart (
      .clk      (clk),
      .rst      (rst),
      .host_tx  (host_tx),
      .uart_tx  (uart_tx),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .tx_start (tx_start),
      .tx_byte  (tx_byte),
      .tx_busy  (tx_busy)
   );

   parse_state_e      state, state_nxt;
   logic              addr_hit;
   logic [7:0]        op;
   logic [DATA_W-1:0] pay, a, b, r, tx_buf;
   logic [2:0]        tx_left;

   logic signed [2*DATA_W-1:0] prod_full;
   logic [DATA_W-1:0]          prod;
   logic                       act;

   assign prod_full = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
   assign prod      = prod_full[DATA_W-1:0];
   assign act       = $signed(r) > 0;
   assign tx_byte   = tx_buf[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      case (state)
         ST_IDLE: if (rx_valid) state_nxt = ST_OP;
         ST_OP: if (rx_valid) begin
            if (has_payload(rx_byte))     state_nxt = ST_PAY0;
            else if (is_exec_op(rx_byte)) state_nxt = ST_EXEC;
            else                          state_nxt = ST_IDLE;
         end
         ST_PAY0: if (rx_valid) state_nxt = ST_PAY1;
         ST_PAY1: if (rx_valid) state_nxt = ST_PAY2;
         ST_PAY2: if (rx_valid) state_nxt = ST_PAY3;
         ST_PAY3: if (rx_valid) state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (addr_hit && (op == OP_OUT_RES || op == OP_OUT_ACT)) state_nxt = ST_SEND;
            else                                                    state_nxt = ST_IDLE;
         end
         ST_SEND: begin
            // stay until the last stop bit has left the wire; rx bytes meanwhile are dropped
            if (tx_left != 3'd0) tx_start  = !tx_busy;
            else if (!tx_busy)   state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_hit <= 1'b0;
         op       <= '0;
         pay      <= '0;
         a        <= '0;
         b        <= '0;
         r        <= '0;
         tx_buf   <= '0;
         tx_left  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (rx_valid) addr_hit <= (rx_byte == DEV_ADDR);
            ST_OP:   if (rx_valid) op <= rx_byte;
            ST_PAY0, ST_PAY1, ST_PAY2, ST_PAY3:
               if (rx_valid) pay <= {rx_byte, pay[DATA_W-1:8]};
            ST_EXEC: if (addr_hit) begin
               case (op)
                  OP_LOAD_A:  a <= pay;
                  OP_LOAD_B:  b <= pay;
                  OP_CLR:     r <= '0;
                  OP_MUL:     r <= prod;
                  OP_MAC:     r <= r + prod;
                  OP_OUT_RES: begin
                     tx_buf  <= r;
                     tx_left <= 3'd4;
                  end
                  OP_OUT_ACT: begin
                     tx_buf  <= {{(DATA_W-1){1'b0}}, act};
                     tx_left <= 3'd1;
                  end
                  default: ;
               endcase
            end
            ST_SEND: if (tx_start) begin
               tx_buf  <= tx_buf >> 8;
               tx_left <= tx_left - 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_core.sv
// Bench for perceptron_core: table of command frames, hand-written corner sequences,
// and randomized commands checked against a plain-arithmetic model of A, B and R.
module tb_perceptron_core;

   localparam int CPB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic host_tx = 1'b1;
   logic uart_tx;

   always #5 clk = ~clk;

   perceptron_core #(.CLK_PER_BIT(CPB), .DEV_ADDR(8'h00)) dut (
      .clk     (clk),
      .rst     (rst),
      .host_tx (host_tx),
      .uart_tx (uart_tx)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int stop_cyc = 0;
   logic [7:0] rxq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // host-side receiver: decodes every 8N1 frame on uart_tx into rxq
   initial begin
      logic [7:0] rb;
      forever begin
         @(negedge clk);
         if (!rst && uart_tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            if (uart_tx === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clk);
                  rb[i] = uart_tx;
               end
               repeat (CPB) @(negedge clk);
               if (uart_tx === 1'b1) rxq.push_back(rb);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] bv, input logic stop);
      @(posedge clk); #1 host_tx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 host_tx = bv[i];
         repeat (CPB) @(posedge clk);
      end
      #1 host_tx = stop;
      stop_cyc = cyc;
      repeat (CPB) @(posedge clk);
      if (!stop) begin
         #1 host_tx = 1'b1;
         repeat (CPB) @(posedge clk);
      end
   endtask

   task automatic send_frame(input logic [63:0] bytes, input int n);
      for (int i = 0; i < n; i++) send_byte(bytes[i*8 +: 8], 1'b1);
   endtask

   task automatic get_resp(input string name, input int n, input logic [31:0] exp);
      int waited;
      logic [31:0] v;
      waited = 0;
      v = '0;
      while (rxq.size() < n && waited < n * 11 * CPB + 100) begin
         @(negedge clk);
         waited++;
      end
      if (rxq.size() < n) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout, got %0d bytes, expected %0d", name, rxq.size(), n);
         rxq.delete();
      end else begin
         for (int i = 0; i < n; i++) v[i*8 +: 8] = rxq.pop_front();
         check(name, v, exp);
      end
   endtask

   typedef struct packed {
      logic [63:0] bytes;
      int          n_in;
      int          n_out;
      logic [31:0] exp;
   } vec_t;

   function automatic vec_t ld(input logic [7:0] ad, input logic [7:0] opc, input logic [31:0] d);
      return '{bytes: {16'h0, d, opc, ad}, n_in: 6, n_out: 0, exp: 32'h0};
   endfunction

   function automatic vec_t cmd(input logic [7:0] ad, input logic [7:0] opc, input int no,
                                input logic [31:0] e);
      return '{bytes: {48'h0, opc, ad}, n_in: 2, n_out: no, exp: e};
   endfunction

   task automatic run_vec(input vec_t t, input string name);
      send_frame(t.bytes, t.n_in);
      if (t.n_out > 0) get_resp(name, t.n_out, t.exp);
   endtask

   function automatic logic [31:0] mul32(input logic [31:0] x, input logic [31:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return p[31:0];
   endfunction

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   vec_t base[$];
   vec_t tbl[$];
   logic [7:0]  ops[10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd4, 8'd9, 8'd200};
   logic [31:0] a_m, b_m, r_m, d, e;
   logic [7:0]  op, ad;
   int          no, viol, lat, waited;

   initial begin
      base.push_back(ld(8'h00, 8'h00, 32'h1));
      base.push_back(ld(8'h00, 8'h01, 32'h1));
      base.push_back(cmd(8'h00, 8'h05, 0, 0));
      base.push_back(cmd(8'h00, 8'h06, 0, 0));
      base.push_back(cmd(8'h00, 8'h02, 4, 32'h0000_0002));

      tbl.push_back(ld(8'h00, 8'h00, 32'hFFFF_FFFF));
      tbl.push_back(ld(8'h00, 8'h01, 32'h0000_0003));
      tbl.push_back(cmd(8'h00, 8'h05, 0, 0));
      tbl.push_back(cmd(8'h00, 8'h02, 4, 32'hFFFF_FFFD));
      tbl.push_back(cmd(8'h00, 8'h07, 1, 32'h0));
      tbl.push_back(ld(8'h00, 8'h00, 32'h0001_0000));
      tbl.push_back(ld(8'h00, 8'h01, 32'h0001_0000));
      tbl.push_back(cmd(8'h00, 8'h05, 0, 0));
      tbl.push_back(cmd(8'h00, 8'h02, 4, 32'h0));
      tbl.push_back(ld(8'h00, 8'h00, 32'h7FFF_FFFF));
      tbl.push_back(ld(8'h00, 8'h01, 32'h0000_0001));
      tbl.push_back(cmd(8'h00, 8'h05, 0, 0));
      tbl.push_back(ld(8'h00, 8'h00, 32'h0000_0001));
      tbl.push_back(cmd(8'h00, 8'h06, 0, 0));
      tbl.push_back(cmd(8'h00, 8'h02, 4, 32'h8000_0000));
      tbl.push_back(cmd(8'h00, 8'h07, 1, 32'h0));
      tbl.push_back(ld(8'h01, 8'h00, 32'h0000_0005));
      tbl.push_back(cmd(8'h00, 8'h02, 4, 32'h8000_0000));
      tbl.push_back(cmd(8'h00, 8'h05, 0, 0));
      tbl.push_back(cmd(8'h00, 8'h02, 4, 32'h0000_0001));
      tbl.push_back(cmd(8'h00, 8'h07, 1, 32'h1));
      tbl.push_back(cmd(8'h00, 8'h09, 0, 0));
      tbl.push_back(cmd(8'h00, 8'h02, 4, 32'h0000_0001));
      tbl.push_back(cmd(8'h01, 8'h02, 0, 0));
      tbl.push_back(cmd(8'h00, 8'h03, 0, 0));
      tbl.push_back(cmd(8'h00, 8'h02, 4, 32'h0));
      tbl.push_back(cmd(8'h00, 8'h07, 1, 32'h0));

      // reset state and a quiet line
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset uart_tx", {31'h0, uart_tx}, 32'h1);
      @(posedge clk); #1 rst = 1'b0;
      viol = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) viol++;
      end
      check("idle line low cycles", viol, 0);
      check("idle frames", rxq.size(), 0);
      run_vec(cmd(8'h00, 8'h02, 4, 32'h0), "reset R");

      for (int rep = 0; rep < 30; rep++)
         for (int i = 0; i < base.size(); i++) run_vec(base[i], $sformatf("rep%0d v%0d", rep, i));
      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // response latency, then reset in the middle of the first response byte (0x23)
      run_vec(ld(8'h00, 8'h00, 32'd5), "ldA");
      run_vec(ld(8'h00, 8'h01, 32'd7), "ldB");
      run_vec(cmd(8'h00, 8'h05, 0, 0), "mul");
      send_frame({48'h0, 8'h02, 8'h00}, 2);
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 4 * CPB) begin
         @(negedge clk);
         waited++;
      end
      lat = cyc - stop_cyc;
      n_checks++;
      if (uart_tx !== 1'b0 || lat > CPB / 2 + 8) begin
         n_fail++;
         $display("FAIL out_res latency: got %0d cycles after stop bit, limit %0d", lat, CPB / 2 + 8);
      end
      repeat (3 * CPB + 2) @(negedge clk);
      check("line low before reset", {31'h0, uart_tx}, 32'h0);
      #1 rst = 1'b1;
      #1 check("uart_tx on reset", {31'h0, uart_tx}, 32'h1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12 * CPB) @(posedge clk);
      rxq.delete();
      run_vec(cmd(8'h00, 8'h05, 0, 0), "mul after reset");
      run_vec(cmd(8'h00, 8'h02, 4, 32'h0), "R after reset");

      // a byte with a low stop bit must not advance the parser
      run_vec(ld(8'h00, 8'h00, 32'd5), "ldA2");
      run_vec(ld(8'h00, 8'h01, 32'd7), "ldB2");
      run_vec(cmd(8'h00, 8'h05, 0, 0), "mul2");
      send_byte(8'h00, 1'b1);
      send_byte(8'h03, 1'b0);
      send_byte(8'h02, 1'b1);
      get_resp("framing error ignored", 4, 32'd35);

      a_m = 32'd5; b_m = 32'd7; r_m = 32'd35;
      for (int k = 0; k < 30; k++) begin
         op = ops[$urandom_range(0, 9)];
         ad = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         d  = rnd32();
         no = 0;
         e  = '0;
         if (ad == 8'h00) begin
            case (op)
               8'd0: a_m = d;
               8'd1: b_m = d;
               8'd3: r_m = '0;
               8'd5: r_m = mul32(a_m, b_m);
               8'd6: r_m = r_m + mul32(a_m, b_m);
               8'd2: begin no = 4; e = r_m; end
               8'd7: begin no = 1; e = ($signed(r_m) > 0) ? 32'h1 : 32'h0; end
               default: ;
            endcase
         end
         if (op == 8'd0 || op == 8'd1) send_frame({16'h0, d, op, ad}, 6);
         else                          send_frame({48'h0, op, ad}, 2);
         if (no > 0) get_resp($sformatf("rand%0d op%0d", k, op), no, e);
      end
      run_vec(cmd(8'h00, 8'h02, 4, r_m), "rand final R");
      repeat (20 * CPB) @(posedge clk);
      check("no stray bytes", rxq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
